// File: rtl/heap_pkg.sv
// Shared encodings for the heap level controller.
// Holds the request opcode encoding and the controller state encoding.
// Imported by heap_level_ctrl.
package heap_pkg;

   // Request opcodes as carried on req_op / dn_req_op.
   typedef enum logic {
      OP_INSERT = 1'b0,
      OP_POP    = 1'b1
   } op_e;

   // Controller states.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD      = 3'd1,
      CMP     = 3'd2,
      DN_REQ  = 3'd3,
      DN_WAIT = 3'd4,
      WR      = 3'd5
   } state_e;

endpackage

// File: rtl/dpram.sv
// Level key storage: 2^LEVEL slots, port a read/write, port b read-only.
// Latency: reads are registered, so data appears the cycle after the address.
// Ports: clk; we_a/addr_a/wdata_a/rdata_a (port a); addr_b/rdata_b (port b).
//        Only the low LEVEL address bits select a slot. Contents are not reset.
module dpram #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int LEVEL      = 1
) (
   input  logic                  clk,
   input  logic                  we_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] wdata_a,
   output logic [DATA_WIDTH-1:0] rdata_a,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   output logic [DATA_WIDTH-1:0] rdata_b
);

   localparam int NSLOT = 1 << LEVEL;

   logic [DATA_WIDTH-1:0] mem [NSLOT];

   always_ff @(posedge clk) begin
      if (we_a) begin
         mem[addr_a[LEVEL-1:0]] <= wdata_a;
      end
      rdata_a <= mem[addr_a[LEVEL-1:0]];
      rdata_b <= mem[addr_b[LEVEL-1:0]];
   end

   // Address bits above the slot index are intentionally ignored.
   if (ADDR_WIDTH > LEVEL) begin : g_hi_addr
      logic unused_hi_addr;
      assign unused_hi_addr = ^{addr_a[ADDR_WIDTH-1:LEVEL], addr_b[ADDR_WIDTH-1:LEVEL]};
   end

endmodule

// File: rtl/heap_level_ctrl.sv
// One level of a pipelined binary heap: INSERT/POP on the two children of parent idx.
// Latency: accept at T, POP response at T+2; refill/carry via downstream request after.
// Backpressure: req_ready only in IDLE; dn_req held until dn_req_ready.
// Ports: clk, rst_n; req_* upstream request; rsp_* upstream POP response;
//        dn_req_* downstream request; dn_rsp_* downstream POP response;
//        busy (not IDLE); err_overflow (sticky, INSERT dropped at bottom level).
// Optional: HEAP_LEVEL_STATS_EN adds occ_cnt, the number of occupied slots.
module heap_level_ctrl
   import heap_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int LEVEL      = 1,
   parameter int LAST       = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_op,
   input  logic [ADDR_WIDTH-1:0] req_idx,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  rsp_valid,
   output logic                  rsp_empty,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  dn_req_valid,
   input  logic                  dn_req_ready,
   output logic                  dn_req_op,
   output logic [ADDR_WIDTH-1:0] dn_req_idx,
   output logic [DATA_WIDTH-1:0] dn_req_data,
   input  logic                  dn_rsp_valid,
   input  logic                  dn_rsp_empty,
   input  logic [DATA_WIDTH-1:0] dn_rsp_data,
`ifdef HEAP_LEVEL_STATS_EN
   output logic [LEVEL:0]        occ_cnt,
`endif
   output logic                  busy,
   output logic                  err_overflow
);

   localparam int NSLOT = 1 << LEVEL;

   state_e                state_q, state_d;
   op_e                   op_q, op_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;     // request key, later the refill key
   logic                  sel_q, sel_d;       // 1 = child b
   logic [NSLOT-1:0]      valid_q, valid_d;
   logic                  err_q, err_d;
   logic                  dn_vld_q, dn_vld_d;
   op_e                   dn_op_q, dn_op_d;
   logic [ADDR_WIDTH-1:0] dn_idx_q, dn_idx_d;
   logic [DATA_WIDTH-1:0] dn_dat_q, dn_dat_d;

   logic [ADDR_WIDTH-1:0] slot_a, slot_b, sel_slot;
   logic                  va, vb;
   logic [DATA_WIDTH-1:0] ka, kb, k_ins, ins_min, ins_max;
   logic                  pop_sel, ins_sel;

   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr_a;
   logic [DATA_WIDTH-1:0] ram_wdata;

   // Children of parent i live at {i,0} and {i,1}; bits above the level drop out.
   assign slot_a   = ADDR_WIDTH'({idx_q, 1'b0});
   assign slot_b   = slot_a | ADDR_WIDTH'(1);
   assign sel_slot = sel_q ? slot_b : slot_a;

   assign va = valid_q[slot_a[LEVEL-1:0]];
   assign vb = valid_q[slot_b[LEVEL-1:0]];

   // POP takes the smaller valid child, INSERT displaces the larger; ties pick a.
   assign pop_sel = (va && vb) ? (kb < ka) : vb;
   assign ins_sel = (kb > ka);
   assign k_ins   = ins_sel ? kb : ka;
   assign ins_min = (data_q < k_ins) ? data_q : k_ins;
   assign ins_max = (data_q < k_ins) ? k_ins : data_q;

   dpram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .LEVEL     (LEVEL)
   ) u_ram (
      .clk    (clk),
      .we_a   (ram_we),
      .addr_a (ram_addr_a),
      .wdata_a(ram_wdata),
      .rdata_a(ka),
      .addr_b (slot_b),
      .rdata_b(kb)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      idx_d      = idx_q;
      data_d     = data_q;
      sel_d      = sel_q;
      valid_d    = valid_q;
      err_d      = err_q;
      dn_vld_d   = dn_vld_q;
      dn_op_d    = dn_op_q;
      dn_idx_d   = dn_idx_q;
      dn_dat_d   = dn_dat_q;
      ram_we     = 1'b0;
      ram_addr_a = slot_a;
      ram_wdata  = data_q;
      rsp_valid  = 1'b0;
      rsp_empty  = 1'b0;
      rsp_data   = '0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d    = op_e'(req_op);
               idx_d   = req_idx;
               data_d  = req_data;
               state_d = RD;
            end
         end

         RD: state_d = CMP;

         CMP: begin
            if (op_q == OP_POP) begin
               rsp_valid = 1'b1;
               if (!va && !vb) begin
                  rsp_empty = 1'b1;
                  state_d   = IDLE;
               end else begin
                  rsp_data = pop_sel ? kb : ka;
                  sel_d    = pop_sel;
                  if (LAST != 0) begin
                     valid_d[pop_sel ? slot_b[LEVEL-1:0] : slot_a[LEVEL-1:0]] = 1'b0;
                     state_d = IDLE;
                  end else begin
                     dn_vld_d = 1'b1;
                     dn_op_d  = OP_POP;
                     dn_idx_d = pop_sel ? slot_b : slot_a;
                     dn_dat_d = '0;
                     state_d  = DN_REQ;
                  end
               end
            end else begin
               ram_we = 1'b1;
               if (!va || !vb) begin
                  ram_addr_a = va ? slot_b : slot_a;
                  valid_d[va ? slot_b[LEVEL-1:0] : slot_a[LEVEL-1:0]] = 1'b1;
                  state_d = IDLE;
               end else begin
                  // Keep the smaller key here, push the larger one down a level.
                  ram_addr_a = ins_sel ? slot_b : slot_a;
                  ram_wdata  = ins_min;
                  sel_d      = ins_sel;
                  if (LAST != 0) begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end else begin
                     dn_vld_d = 1'b1;
                     dn_op_d  = OP_INSERT;
                     dn_idx_d = ins_sel ? slot_b : slot_a;
                     dn_dat_d = ins_max;
                     state_d  = DN_REQ;
                  end
               end
            end
         end

         DN_REQ: begin
            if (dn_req_ready) begin
               dn_vld_d = 1'b0;
               state_d  = (dn_op_q == OP_POP) ? DN_WAIT : IDLE;
            end
         end

         DN_WAIT: begin
            if (dn_rsp_valid) begin
               if (dn_rsp_empty) begin
                  valid_d[sel_slot[LEVEL-1:0]] = 1'b0;
                  state_d = IDLE;
               end else begin
                  data_d  = dn_rsp_data;
                  state_d = WR;
               end
            end
         end

         WR: begin
            ram_we     = 1'b1;
            ram_addr_a = sel_slot;
            ram_wdata  = data_q;
            valid_d[sel_slot[LEVEL-1:0]] = 1'b1;
            state_d    = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= OP_INSERT;
         idx_q    <= '0;
         data_q   <= '0;
         sel_q    <= 1'b0;
         valid_q  <= '0;
         err_q    <= 1'b0;
         dn_vld_q <= 1'b0;
         dn_op_q  <= OP_INSERT;
         dn_idx_q <= '0;
         dn_dat_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         sel_q    <= sel_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         dn_vld_q <= dn_vld_d;
         dn_op_q  <= dn_op_d;
         dn_idx_q <= dn_idx_d;
         dn_dat_q <= dn_dat_d;
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign err_overflow = err_q;
   assign dn_req_valid = dn_vld_q;
   assign dn_req_op    = dn_op_q;
   assign dn_req_idx   = dn_idx_q;
   assign dn_req_data  = dn_dat_q;

`ifdef HEAP_LEVEL_STATS_EN
   always_comb begin
      occ_cnt = '0;
      for (int s = 0; s < NSLOT; s++) begin
         occ_cnt = occ_cnt + (LEVEL+1)'(valid_q[s]);
      end
   end
`endif

endmodule

// File: doc/heap_level_ctrl.md
HEAP_LEVEL_CTRL -- requirements
Module: heap_level_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_WIDTH, 32, key width; ADDR_WIDTH, 5, slot index width (>= LEVEL); LEVEL, 1, heap level served (>= 1, 2^LEVEL slots); LAST, 0, 1 = bottom level with no downstream.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 Ports SHALL be (name, dir, width, meaning): clk, in, 1, clock; rst_n, in, 1, async active-low reset.
REQ-004 req_valid in 1, req_ready out 1, req_op in 1 (0 = INSERT, 1 = POP), req_idx in ADDR_WIDTH (parent index i, low LEVEL-1 bits used), req_data in DATA_WIDTH: upstream request.
REQ-005 rsp_valid out 1, rsp_empty out 1, rsp_data out DATA_WIDTH: upstream POP response.
REQ-006 dn_req_valid out 1, dn_req_ready in 1, dn_req_op out 1, dn_req_idx out ADDR_WIDTH, dn_req_data out DATA_WIDTH: downstream request.
REQ-007 dn_rsp_valid in 1, dn_rsp_empty in 1, dn_rsp_data in DATA_WIDTH: downstream POP response.
REQ-008 busy out 1 (state != IDLE); err_overflow out 1 (sticky overflow).

Function
REQ-009 States SHALL be IDLE, RD, CMP, DN_REQ, DN_WAIT, WR; req_ready = 1 only in IDLE.
REQ-010 Accept (cycle T) SHALL latch op/idx/data and go to RD; RD drives port a addr {i,0}, port b addr {i,1}; CMP (T+2) uses registered RAM outputs and per-slot valid bitmap.
REQ-011 All key comparisons SHALL be unsigned, DATA_WIDTH wide; ties select child a.
REQ-012 POP, no valid child: rsp_valid pulse at T+2 with rsp_empty = 1, return to IDLE, no downstream traffic.
REQ-013 POP, valid child present: sel = smaller valid child; rsp_valid pulse at T+2, rsp_data = key[sel], rsp_empty = 0.
REQ-014 POP refill: LAST = 1 clears valid[sel], goes IDLE; LAST = 0 goes DN_REQ (op POP, idx = slot sel), then DN_WAIT.
REQ-015 DN_WAIT on dn_rsp_valid: dn_rsp_empty = 1 clears valid[sel]; otherwise goes WR, writes dn_rsp_data to sel, sets valid; then IDLE.
REQ-016 INSERT, a free child exists (a first): write req_data there in CMP, set valid, go IDLE.
REQ-017 INSERT, both full: sel = larger child; write min(req_data, key[sel]) to sel; carry max downstream as dn_req INSERT to slot sel (LAST = 0), or set err_overflow and discard it (LAST = 1).
REQ-018 dn_req_valid and payload SHALL be held stable until dn_req_ready; handshake completes in the same cycle.
REQ-019 All RAM writes SHALL use port a; a write completes before IDLE so the next request reads updated data.
REQ-020 No upstream response SHALL be produced for INSERT.

Reset
REQ-021 Reset, including mid-operation, SHALL force IDLE and clear the valid bitmap, err_overflow, rsp_valid, rsp_empty, rsp_data, dn_req_valid and all dn_req payload outputs to 0; RAM contents are not cleared.

Configuration
REQ-022 With HEAP_LEVEL_STATS_EN defined, output occ_cnt [LEVEL:0] SHALL equal the number of set valid bits (reset 0); without it the port and its logic SHALL be absent.

Structure
REQ-023 Package heap_pkg SHALL hold op encodings (OP_INSERT, OP_POP) and the state encoding.
REQ-024 The level storage SHALL be one instance of the existing dpram sub-module (DATA_WIDTH, ADDR_WIDTH, LEVEL passed through).

Verification (DATA_WIDTH = 8, LEVEL = 2)
REQ-025 Reset, POP idx 1 -> rsp_valid at T+2, rsp_empty = 1, dn_req_valid never asserted.
REQ-026 INSERT 0x30 idx 1, then INSERT 0x10 idx 1 -> slot 2 = 0x30, slot 3 = 0x10, both valid, no dn_req.
REQ-027 INSERT 0x20 idx 1 (LAST = 0) -> slot 2 = 0x20; dn_req INSERT idx 2 data 0x30 held until dn_req_ready.
REQ-028 POP idx 1 (slots 0x20/0x10) -> rsp_data 0x10 at T+2; dn_req POP idx 3; dn_rsp_data 0x15 -> slot 3 = 0x15.
REQ-029 LAST = 1, both children full, INSERT -> err_overflow = 1 and stays 1 until rst_n low.
REQ-030 rst_n low during DN_WAIT -> busy = 0, req_ready = 1 after release; next POP gives rsp_empty = 1; occ_cnt = 0 with the macro.
